uart_rx_ctrl: RTL and testbench

//  Sequencer for the 9-bit receive shift register (7 data + parity + stop).
//  - Detects and validates the start bit from an oversampling tick.
//  - Drives the register's enable, mid-bit sample tick and serial bit.
//  - Checks parity and stop bit.
//  - Presents each completed frame to the host via a valid/ack handshake with error flags.
//  - Sits between the RX pin synchroniser/baud generator and the shift register.

---
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for a 9-bit shift register (7 data + parity + stop):
// start-bit qualification, mid-bit sample ticks, parity/stop checks and host handshake.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_pin,
    input  logic os_tick,
    output logic sr_en,
    output logic sr_tick,
    output logic sr_serial,
    output logic rx_valid,
    input  logic rx_ack,
    output logic parity_err,
    output logic frame_err,
    output logic overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, CHECK, DONE} state_t;

    state_t        state, state_n;
    logic          sync1, rxs;
    logic [CW-1:0] os_cnt;
    logic [3:0]    bit_cnt;
    logic          par, stop, perr, ferr, armed;
    logic          start_go;

    assign sr_serial = rxs;
    assign start_go  = os_tick && !rxs && armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            rxs   <= 1'b0;
        end else begin
            sync1 <= rx_pin;
            rxs   <= sync1;
        end
    end

    always_comb begin
        state_n = state;
        sr_en   = 1'b0;
        sr_tick = 1'b0;
        case (state)
            IDLE:  if (start_go) state_n = START;
            START: begin
                sr_en = 1'b1;
                if (os_tick && os_cnt == HALF) state_n = rxs ? IDLE : DATA;
            end
            DATA: begin
                sr_en = 1'b1;
                if (os_tick && os_cnt == LAST) begin
                    sr_tick = 1'b1;
                    if (bit_cnt == 4'd8) state_n = CHECK;
                end
            end
            CHECK: begin
                sr_en   = 1'b1;
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            stop    <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            armed   <= 1'b1;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (rxs) armed <= 1'b1;
                    if (start_go) begin
                        os_cnt <= '0;
                        par    <= 1'b0;
                    end
                end
                START: if (os_tick) begin
                    if (os_cnt == HALF) begin
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                DATA: if (os_tick) begin
                    if (os_cnt == LAST) begin
                        os_cnt <= '0;
                        if (bit_cnt == 4'd8) begin
                            stop <= rxs;
                        end else begin
                            par     <= par ^ rxs;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    perr <= (par != PARITY_ODD);
                    ferr <= ~stop;
                end
                // a break frame must see the line return high before re-arming
                DONE:    armed <= stop;
                default: ;
            endcase
        end
    end

    // frame completion takes priority over a coincident ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (state == DONE) begin
            rx_valid   <= 1'b1;
            parity_err <= perr;
            frame_err  <= ferr;
            if (rx_valid && !rx_ack) overrun_err <= 1'b1;
        end else if (rx_ack && rx_valid) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: even-parity DUT plus an odd-parity twin on shared stimulus.
module tb_uart_rx_ctrl;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic reset, rx_pin, os_tick, rx_ack, mon_clr;
    logic sr_en, sr_tick, sr_serial, rx_valid, parity_err, frame_err, overrun_err;
    logic o_sr_en, o_sr_tick, o_sr_serial, o_rx_valid, o_parity_err, o_frame_err, o_overrun_err;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .reset(reset), .rx_pin(rx_pin), .os_tick(os_tick),
        .sr_en(sr_en), .sr_tick(sr_tick), .sr_serial(sr_serial),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err)
    );

    uart_rx_ctrl #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .rx_pin(rx_pin), .os_tick(os_tick),
        .sr_en(o_sr_en), .sr_tick(o_sr_tick), .sr_serial(o_sr_serial),
        .rx_valid(o_rx_valid), .rx_ack(rx_ack), .parity_err(o_parity_err),
        .frame_err(o_frame_err), .overrun_err(o_overrun_err)
    );

    // activity monitor on the even-parity DUT
    int   cyc = 0;
    int   tick_cnt = 0, en_cnt = 0, first_tick = 0, last_tick = 0, vld_cyc = 0;
    logic vld_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        vld_q <= rx_valid;
        if (mon_clr) begin
            tick_cnt <= 0;
            en_cnt   <= 0;
            vld_cyc  <= 0;
        end else begin
            if (sr_tick) begin
                if (tick_cnt == 0) first_tick <= cyc;
                last_tick <= cyc;
                tick_cnt  <= tick_cnt + 1;
            end
            if (sr_en) en_cnt <= en_cnt + 1;
            if (rx_valid && !vld_q) vld_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) os_tick = 1'b1;
        @(negedge clk) os_tick = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk) rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
    endtask

    // start + 7 data (LSB first) + parity + stop; ack_done pulses rx_ack in the DONE cycle
    task automatic send_frame(input logic [6:0] data, input logic pbit, input logic sbit,
                              input int nbits, input bit ack_done);
        logic [9:0] f;
        f = {sbit, pbit, data, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            for (int t = 0; t < OS; t++) begin
                @(negedge clk);
                if (t == 0) rx_pin = f[b];
                os_tick = 1'b1;
                if (ack_done && b == 9 && t == 10) rx_ack = 1'b1;
                @(negedge clk);
                os_tick = 1'b0;
                rx_ack  = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; rx_pin = 1'b1; os_tick = 1'b0; rx_ack = 1'b0; mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", {sr_en, sr_tick, sr_serial, rx_valid, parity_err, frame_err, overrun_err}, 0);
        reset = 1'b0; mon_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_serial", sr_serial, 1);

        // 0x55 even parity, clean
        clr();
        send_frame(7'h55, 1'b0, 1'b1, 10, 1'b0);
        chk("f55_ticks", tick_cnt, 9);
        chk("f55_spacing", last_tick - first_tick, 8 * OS * 2);
        // monitor sees the rise one edge after it happens: 2 clk latency reads as 3
        chk("f55_latency", vld_cyc - last_tick, 3);
        chk("f55_flags", {rx_valid, parity_err, frame_err, overrun_err}, 4'b1000);
        chk("f55_odd_perr", o_parity_err, 1);
        ack();
        chk("ack_clr", {rx_valid, parity_err, frame_err, overrun_err}, 0);

        // parity bit flipped
        send_frame(7'h55, 1'b1, 1'b1, 10, 1'b0);
        chk("par1_even", {rx_valid, parity_err, frame_err}, 3'b110);
        chk("par1_odd", {o_rx_valid, o_parity_err, o_frame_err}, 3'b100);
        ack();

        // start glitch
        clr();
        @(negedge clk) rx_pin = 1'b0;
        repeat (5) tick();
        rx_pin = 1'b1;
        repeat (OS) tick();
        chk("glitch_ticks", tick_cnt, 0);
        chk("glitch_en_seen", en_cnt != 0, 1);
        chk("glitch_idle", {sr_en, rx_valid}, 2'b00);

        // stop bit 0, line held low: no restart until line returns high
        send_frame(7'h55, 1'b0, 1'b0, 10, 1'b0);
        chk("ferr_flags", {rx_valid, parity_err, frame_err}, 3'b101);
        ack();
        clr();
        repeat (40) tick();
        chk("break_no_start", en_cnt, 0);
        @(negedge clk) rx_pin = 1'b1;
        repeat (4) tick();
        clr();
        send_frame(7'h55, 1'b0, 1'b1, 10, 1'b0);
        chk("rearm_ticks", tick_cnt, 9);
        chk("rearm_flags", {rx_valid, parity_err, frame_err}, 3'b100);
        ack();

        // overrun: bad-parity frame then clean frame, no ack between
        send_frame(7'h55, 1'b1, 1'b1, 10, 1'b0);
        chk("ovr_first", {rx_valid, parity_err, overrun_err}, 3'b110);
        send_frame(7'h55, 1'b0, 1'b1, 10, 1'b0);
        chk("ovr_second", {rx_valid, parity_err, frame_err, overrun_err}, 4'b1001);
        ack();
        chk("ovr_ack_clr", {rx_valid, parity_err, frame_err, overrun_err}, 0);

        // ack coinciding with DONE: new frame kept, no overrun
        send_frame(7'h55, 1'b0, 1'b1, 10, 1'b0);
        send_frame(7'h55, 1'b1, 1'b1, 10, 1'b1);
        chk("ack_done", {rx_valid, parity_err, overrun_err}, 3'b110);
        ack();

        // reset at bit_cnt 4, then a clean 0x2A
        clr();
        send_frame(7'h2A, 1'b1, 1'b1, 5, 1'b0);
        chk("mid_ticks", tick_cnt, 4);
        chk("mid_en", sr_en, 1);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("mid_reset_outs", {sr_en, sr_tick, sr_serial, rx_valid, parity_err, frame_err, overrun_err}, 0);
        rx_pin = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_no_valid", rx_valid, 0);
        clr();
        send_frame(7'h2A, 1'b1, 1'b1, 10, 1'b0);
        chk("f2a_ticks", tick_cnt, 9);
        chk("f2a_flags", {rx_valid, parity_err, frame_err, overrun_err}, 4'b1000);
        chk("f2a_odd_perr", o_parity_err, 1);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
